wgt_loader: RTL and testbench

- Downstream consumer of the weight parser's 24-bit row stream.
- Pulls one kernel row per read strobe and assembles NUM_KERNELS 3x3 kernels of 8-bit weights into a shadow bank.
- Copies the shadow bank into an active bank, which drives the PE array weight inputs, when the PE controller requests a swap.
- Double buffering lets the next layer's weights load while the current layer computes.

---
 rtl/wgt_loader_pkg.sv | 33 +++
 rtl/wgt_bank_reg.sv | 44 ++++
 rtl/wgt_loader.sv | 182 ++++++++++++++++++
 tb/tb_wgt_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wgt_loader_pkg.sv
// wgt_loader_pkg: shared constants, FSM encodings and bank index helpers for
// the weight loader. Imported by wgt_loader and its testbench.
package wgt_loader_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int KERNEL_DIM  = 3;
    localparam int ROW_WIDTH   = DATA_WIDTH * KERNEL_DIM;
    localparam int NUM_KERNELS = 16;
    localparam int NUM_ROWS    = NUM_KERNELS * KERNEL_DIM;
    localparam int BANK_WIDTH  = NUM_ROWS * ROW_WIDTH;
    localparam int KER_CNT_W   = $clog2(NUM_KERNELS);
    localparam int ROW_CNT_W   = $clog2(KERNEL_DIM);
    localparam int ROW_ADDR_W  = $clog2(NUM_ROWS);
    localparam int CKSUM_W     = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    // Row slot inside a bank: kernel-major, then kernel row.
    function automatic logic [ROW_ADDR_W-1:0] bank_row_addr(
        input logic [KER_CNT_W-1:0] ker,
        input logic [ROW_CNT_W-1:0] row
    );
        return ROW_ADDR_W'(int'(ker) * KERNEL_DIM + int'(row));
    endfunction

    // Flat byte offset of weight (kernel, row, column) on the bank bus.
    function automatic int bank_byte_idx(input int ker, input int row, input int col);
        return ker * KERNEL_DIM * KERNEL_DIM + row * KERNEL_DIM + col;
    endfunction

endpackage

// File: rtl/wgt_bank_reg.sv
// wgt_bank_reg: row-addressed register file holding one weight bank.
// Ports:
//   clk, rst_n            clock, async active-low reset (bank clears to 0)
//   row_we/addr/wdata     single-row write port
//   bank_we/bank_wdata    whole-bank write port (wins over the row port)
//   bank_rdata            full flattened bank, row i at bits [i*ROW_WIDTH +: ROW_WIDTH]
module wgt_bank_reg #(
    parameter int NUM_ROWS  = 48,
    parameter int ROW_WIDTH = 24,
    parameter int ADDR_W    = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          row_we,
    input  logic [ADDR_W-1:0]             row_addr,
    input  logic [ROW_WIDTH-1:0]          row_wdata,
    input  logic                          bank_we,
    input  logic [NUM_ROWS*ROW_WIDTH-1:0] bank_wdata,
    output logic [NUM_ROWS*ROW_WIDTH-1:0] bank_rdata
);

    logic [NUM_ROWS*ROW_WIDTH-1:0] bank_q;
    logic [NUM_ROWS*ROW_WIDTH-1:0] bank_d;

    always_comb begin
        bank_d = bank_q;
        if (bank_we) begin
            bank_d = bank_wdata;
        end else if (row_we) begin
            bank_d[int'(row_addr) * ROW_WIDTH +: ROW_WIDTH] = row_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

    assign bank_rdata = bank_q;

endmodule

// File: rtl/wgt_loader.sv
// wgt_loader: pulls 24-bit kernel rows from the weight parser into a shadow
// bank and copies it into the active bank (driving the PE array) on pe_swap.
// Optional build macro WGT_LOADER_CKSUM_EN adds wgt_cksum, a mod-2^16 sum of
// the captured weight bytes latched at swap time.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start_conv_pulse    abort any load, return to IDLE (active bank kept)
//   load_req            request to fill the shadow bank
//   wgt_avail, wgt_row  parser row valid / row data
//   wgt_read            row consumed this cycle
//   pe_swap             make the shadow bank active (only honoured in FULL)
//   shadow_full         shadow bank holds a complete set of kernels
//   load_done           one-cycle pulse after the last row is captured
//   wgt_bus             active bank, flattened
//   busy                FSM is in LOAD
//
// state | meaning
// IDLE  | waiting for load_req
// LOAD  | capturing rows into the shadow bank
// FULL  | shadow bank complete, waiting for pe_swap
module wgt_loader
    import wgt_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_conv_pulse,
    input  logic                  load_req,
    input  logic                  wgt_avail,
    input  logic [ROW_WIDTH-1:0]  wgt_row,
    output logic                  wgt_read,
    input  logic                  pe_swap,
    output logic                  shadow_full,
    output logic                  load_done,
    output logic [BANK_WIDTH-1:0] wgt_bus,
`ifdef WGT_LOADER_CKSUM_EN
    output logic [CKSUM_W-1:0]    wgt_cksum,
`endif
    output logic                  busy
);

    logic [1:0]           state_q, state_d;
    logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [KER_CNT_W-1:0] ker_cnt_q, ker_cnt_d;
    logic                 shadow_full_q, shadow_full_d;
    logic                 load_done_q, load_done_d;
    logic                 swap;
    logic [BANK_WIDTH-1:0] shadow_bus;

    // An aborting start_conv_pulse must not consume a parser row that is
    // then thrown away, so the read strobe is gated by it as well.
    assign wgt_read = (state_q == ST_LOAD) && wgt_avail && !start_conv_pulse;

    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        ker_cnt_d     = ker_cnt_q;
        shadow_full_d = shadow_full_q;
        load_done_d   = 1'b0;
        swap          = 1'b0;
        if (start_conv_pulse) begin
            row_cnt_d     = '0;
            ker_cnt_d     = '0;
            shadow_full_d = 1'b0;
            state_d       = load_req ? ST_LOAD : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_req) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (wgt_read) begin
                        if (row_cnt_q == ROW_CNT_W'(KERNEL_DIM - 1)) begin
                            row_cnt_d = '0;
                            if (ker_cnt_q == KER_CNT_W'(NUM_KERNELS - 1)) begin
                                ker_cnt_d     = '0;
                                load_done_d   = 1'b1;
                                shadow_full_d = 1'b1;
                                state_d       = ST_FULL;
                            end else begin
                                ker_cnt_d = ker_cnt_q + 1'b1;
                            end
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (pe_swap) begin
                        swap          = 1'b1;
                        shadow_full_d = 1'b0;
                        state_d       = load_req ? ST_LOAD : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            row_cnt_q     <= '0;
            ker_cnt_q     <= '0;
            shadow_full_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            ker_cnt_q     <= ker_cnt_d;
            shadow_full_q <= shadow_full_d;
            load_done_q   <= load_done_d;
        end
    end

    wgt_bank_reg #(
        .NUM_ROWS  (NUM_ROWS),
        .ROW_WIDTH (ROW_WIDTH),
        .ADDR_W    (ROW_ADDR_W)
    ) u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_we     (wgt_read),
        .row_addr   (bank_row_addr(ker_cnt_q, row_cnt_q)),
        .row_wdata  (wgt_row),
        .bank_we    (1'b0),
        .bank_wdata ('0),
        .bank_rdata (shadow_bus)
    );

    wgt_bank_reg #(
        .NUM_ROWS  (NUM_ROWS),
        .ROW_WIDTH (ROW_WIDTH),
        .ADDR_W    (ROW_ADDR_W)
    ) u_active (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_we     (1'b0),
        .row_addr   ('0),
        .row_wdata  ('0),
        .bank_we    (swap),
        .bank_wdata (shadow_bus),
        .bank_rdata (wgt_bus)
    );

`ifdef WGT_LOADER_CKSUM_EN
    logic [CKSUM_W-1:0] cksum_run_q, cksum_run_d;
    logic [CKSUM_W-1:0] wgt_cksum_q, wgt_cksum_d;
    logic [CKSUM_W-1:0] row_sum;

    always_comb begin
        row_sum = '0;
        for (int j = 0; j < KERNEL_DIM; j++) begin
            row_sum = row_sum + CKSUM_W'(wgt_row[j*DATA_WIDTH +: DATA_WIDTH]);
        end
        cksum_run_d = cksum_run_q;
        // Cleared on every entry to LOAD, including swap+load_req and restart.
        if (start_conv_pulse || ((state_d == ST_LOAD) && (state_q != ST_LOAD))) begin
            cksum_run_d = '0;
        end else if (wgt_read) begin
            cksum_run_d = cksum_run_q + row_sum;
        end
        wgt_cksum_d = swap ? cksum_run_q : wgt_cksum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_run_q <= '0;
            wgt_cksum_q <= '0;
        end else begin
            cksum_run_q <= cksum_run_d;
            wgt_cksum_q <= wgt_cksum_d;
        end
    end

    assign wgt_cksum = wgt_cksum_q;
`endif

    assign shadow_full = shadow_full_q;
    assign load_done   = load_done_q;
    assign busy        = (state_q == ST_LOAD);

endmodule

// File: tb/tb_wgt_loader.sv
`timescale 1ns/1ps
module tb_wgt_loader;
    import wgt_loader_pkg::*;

    localparam int NBYTES = NUM_ROWS * KERNEL_DIM;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_conv_pulse = 1'b0;
    logic load_req = 1'b0;
    logic wgt_avail = 1'b0;
    logic pe_swap = 1'b0;
    logic [ROW_WIDTH-1:0] wgt_row = '0;
    logic wgt_read, shadow_full, load_done, busy;
    logic [BANK_WIDTH-1:0] wgt_bus;
`ifdef WGT_LOADER_CKSUM_EN
    logic [15:0] wgt_cksum;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a load writes row n of the load to bytes 3n..3n+2.
    logic [7:0]  shadow_m [NBYTES];
    logic [7:0]  active_m [NBYTES];
    bit          m_full;
    logic [15:0] m_run;
    logic [15:0] m_cksum;

    wgt_loader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_conv_pulse (start_conv_pulse),
        .load_req         (load_req),
        .wgt_avail        (wgt_avail),
        .wgt_row          (wgt_row),
        .wgt_read         (wgt_read),
        .pe_swap          (pe_swap),
        .shadow_full      (shadow_full),
        .load_done        (load_done),
        .wgt_bus          (wgt_bus),
`ifdef WGT_LOADER_CKSUM_EN
        .wgt_cksum        (wgt_cksum),
`endif
        .busy             (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [BANK_WIDTH-1:0] expected_bus();
        logic [BANK_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NBYTES; i++) v[i*8 +: 8] = active_m[i];
        return v;
    endfunction

    function automatic logic [BANK_WIDTH-1:0] ramp_bus();
        logic [BANK_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NBYTES; i++) v[i*8 +: 8] = 8'(i % 256);
        return v;
    endfunction

    function automatic int first_bad(input logic [BANK_WIDTH-1:0] a, input logic [BANK_WIDTH-1:0] b);
        for (int i = 0; i < NBYTES; i++) if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
        return 0;
    endfunction

    function automatic logic [23:0] pattern_row(input int n);
        logic [7:0] r;
        r = 8'(3 * n);
        return {r + 8'd2, r + 8'd1, r};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) begin
            shadow_m[i] = 8'h00;
            active_m[i] = 8'h00;
        end
        m_full = 1'b0;
        m_run = '0;
        m_cksum = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start_conv_pulse = 1'b0;
        load_req = 1'b0;
        wgt_avail = 1'b0;
        pe_swap = 1'b0;
        wgt_row = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        m_run = '0;
    endtask

    task automatic do_swap(input bit with_load);
        @(negedge clk);
        pe_swap = 1'b1;
        load_req = with_load;
        @(negedge clk);
        pe_swap = 1'b0;
        load_req = 1'b0;
        if (m_full) begin
            for (int i = 0; i < NBYTES; i++) active_m[i] = shadow_m[i];
            m_cksum = m_run;
            m_full = 1'b0;
        end
        if (with_load) m_run = '0;
    endtask

    // stall_mode: 0 always valid, 1 pattern 1,0,0,1, 2 random
    // data_mode:  0 ramp pattern, 1 fixed_row, 2 random
    task automatic drive_rows(input int base, input int nrows, input int extra,
                              input int stall_mode, input int data_mode,
                              input logic [23:0] fixed_row,
                              output int reads, output int dones, output int bad_reads,
                              output int done_gap, output bit timeout);
        int cyc, last_rd, post;
        bit avail;
        logic [23:0] row;
        reads = 0; dones = 0; bad_reads = 0; done_gap = -1; timeout = 1'b0;
        cyc = 0; last_rd = -100; post = 0;
        while (((reads < nrows) || (post < extra)) && !timeout) begin
            @(negedge clk);
            if (load_done) begin
                dones++;
                done_gap = cyc - last_rd;
            end
            case (stall_mode)
                1: avail = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2: avail = ($urandom_range(0, 3) != 0);
                default: avail = 1'b1;
            endcase
            if (reads >= nrows) begin
                avail = 1'b1;
                post++;
                row = 24'hDEADBE;
            end else begin
                case (data_mode)
                    1: row = fixed_row;
                    2: row = 24'($urandom);
                    default: row = pattern_row(base + reads);
                endcase
            end
            wgt_avail = avail;
            wgt_row = row;
            #1;
            if (wgt_read === 1'b1) begin
                if (!avail) bad_reads++;
                if (reads < nrows) begin
                    for (int j = 0; j < 3; j++) begin
                        shadow_m[3*(base+reads)+j] = row[8*j +: 8];
                        m_run = m_run + 16'(row[8*j +: 8]);
                    end
                    if (base + reads == NUM_ROWS - 1) m_full = 1'b1;
                end
                reads++;
                last_rd = cyc;
            end
            cyc++;
            if (cyc > 1000) timeout = 1'b1;
        end
        @(negedge clk);
        wgt_avail = 1'b0;
        if (load_done) begin
            dones++;
            done_gap = cyc - last_rd;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        wgt_avail = 1'b1;
        #1;
        checks++; if (wgt_read !== 1'b0) begin errors++; $display("FAIL reset_wgt_read got %b expected 0", wgt_read); end
        checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL reset_shadow_full got %b expected 0", shadow_full); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b expected 0", load_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (wgt_bus !== '0) begin errors++; $display("FAIL reset_wgt_bus byte %0d got %02h expected 00", first_bad(wgt_bus, '0), wgt_bus[first_bad(wgt_bus, '0)*8 +: 8]); end
`ifdef WGT_LOADER_CKSUM_EN
        checks++; if (wgt_cksum !== 16'h0) begin errors++; $display("FAIL reset_cksum got %04h expected 0000", wgt_cksum); end
`endif
        wgt_avail = 1'b0;
        do_swap(1'b0);
        checks++; if (wgt_bus !== '0) begin errors++; $display("FAIL idle_swap_bus got nonzero expected 0"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_swap_busy got %b expected 0", busy); end
    endtask

    task automatic test_basic_load();
        int rd, dn, bad, gap;
        bit to;
        start_load();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b expected 1", busy); end
        drive_rows(0, NUM_ROWS, 3, 0, 0, 24'h0, rd, dn, bad, gap, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout reads %0d expected %0d", rd, NUM_ROWS); end
        checks++; if (rd !== NUM_ROWS) begin errors++; $display("FAIL basic_reads got %0d expected %0d", rd, NUM_ROWS); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_count got %0d expected 1", dn); end
        checks++; if (gap !== 1) begin errors++; $display("FAIL basic_done_latency got %0d expected 1", gap); end
        checks++; if (shadow_full !== 1'b1) begin errors++; $display("FAIL basic_shadow_full got %b expected 1", shadow_full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b expected 0", busy); end
        checks++; if (wgt_bus !== '0) begin errors++; $display("FAIL basic_bus_before_swap got nonzero expected 0"); end
    endtask

    task automatic test_swap();
        logic [BANK_WIDTH-1:0] exp;
        // load_req without pe_swap while FULL must be ignored
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
        checks++; if (busy !== 1'b0 || shadow_full !== 1'b1) begin errors++; $display("FAIL full_load_req_ignored got busy %b full %b expected 0 1", busy, shadow_full); end
        do_swap(1'b0);
        exp = ramp_bus();
        checks++; if (wgt_bus !== exp) begin errors++; $display("FAIL swap_bus byte %0d got %02h expected %02h", first_bad(wgt_bus, exp), wgt_bus[first_bad(wgt_bus, exp)*8 +: 8], exp[first_bad(wgt_bus, exp)*8 +: 8]); end
        checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL swap_shadow_full got %b expected 0", shadow_full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swap_busy got %b expected 0", busy); end
        do_swap(1'b0);
        checks++; if (wgt_bus !== exp) begin errors++; $display("FAIL idle_reswap_bus byte %0d changed", first_bad(wgt_bus, exp)); end
    endtask

    task automatic test_stall();
        int rd, dn, bad, gap;
        bit to;
        logic [BANK_WIDTH-1:0] exp;
        start_load();
        drive_rows(0, NUM_ROWS, 2, 1, 0, 24'h0, rd, dn, bad, gap, to);
        checks++; if (to) begin errors++; $display("FAIL stall_timeout reads %0d expected %0d", rd, NUM_ROWS); end
        checks++; if (rd !== NUM_ROWS) begin errors++; $display("FAIL stall_reads got %0d expected %0d", rd, NUM_ROWS); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_read_without_avail got %0d expected 0", bad); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL stall_done_count got %0d expected 1", dn); end
        do_swap(1'b0);
        exp = ramp_bus();
        checks++; if (wgt_bus !== exp) begin errors++; $display("FAIL stall_bus byte %0d got %02h expected %02h", first_bad(wgt_bus, exp), wgt_bus[first_bad(wgt_bus, exp)*8 +: 8], exp[first_bad(wgt_bus, exp)*8 +: 8]); end
    endtask

    task automatic test_random_load();
        int rd, dn, bad, gap;
        bit to;
        logic [BANK_WIDTH-1:0] exp;
        start_load();
        drive_rows(0, NUM_ROWS, 2, 2, 2, 24'h0, rd, dn, bad, gap, to);
        checks++; if (to || rd !== NUM_ROWS) begin errors++; $display("FAIL rand_reads got %0d expected %0d", rd, NUM_ROWS); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rand_read_without_avail got %0d expected 0", bad); end
        checks++; if (dn !== 1 || gap !== 1) begin errors++; $display("FAIL rand_done got count %0d latency %0d expected 1 1", dn, gap); end
        do_swap(1'b0);
        exp = expected_bus();
        checks++; if (wgt_bus !== exp) begin errors++; $display("FAIL rand_bus byte %0d got %02h expected %02h", first_bad(wgt_bus, exp), wgt_bus[first_bad(wgt_bus, exp)*8 +: 8], exp[first_bad(wgt_bus, exp)*8 +: 8]); end
`ifdef WGT_LOADER_CKSUM_EN
        checks++; if (wgt_cksum !== m_cksum) begin errors++; $display("FAIL rand_cksum got %04h expected %04h", wgt_cksum, m_cksum); end
`endif
    endtask

    task automatic test_abort();
        int rd, dn, bad, gap;
        bit to;
        logic [BANK_WIDTH-1:0] exp, held;
        held = wgt_bus;
        start_load();
        drive_rows(0, 20, 0, 0, 2, 24'h0, rd, dn, bad, gap, to);
        @(negedge clk); start_conv_pulse = 1'b1;
        @(negedge clk); start_conv_pulse = 1'b0;
        m_full = 1'b0;
        checks++; if (busy !== 1'b0 || shadow_full !== 1'b0) begin errors++; $display("FAIL abort_state got busy %b full %b expected 0 0", busy, shadow_full); end
        checks++; if (wgt_bus !== held) begin errors++; $display("FAIL abort_active_kept byte %0d changed", first_bad(wgt_bus, held)); end
        start_load();
        drive_rows(0, NUM_ROWS, 3, 0, 1, 24'hA5A5A5, rd, dn, bad, gap, to);
        checks++; if (to || rd !== NUM_ROWS) begin errors++; $display("FAIL abort_reload_reads got %0d expected %0d", rd, NUM_ROWS); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL abort_done_count got %0d expected 1", dn); end
        do_swap(1'b0);
        exp = '0;
        for (int i = 0; i < NBYTES; i++) exp[i*8 +: 8] = 8'hA5;
        checks++; if (wgt_bus !== exp) begin errors++; $display("FAIL abort_bus byte %0d got %02h expected a5", first_bad(wgt_bus, exp), wgt_bus[first_bad(wgt_bus, exp)*8 +: 8]); end
    endtask

    task automatic test_restart();
        int rd, dn, bad, gap;
        bit to;
        logic [BANK_WIDTH-1:0] exp;
        start_load();
        drive_rows(0, 10, 0, 0, 2, 24'h0, rd, dn, bad, gap, to);
        @(negedge clk); start_conv_pulse = 1'b1; load_req = 1'b1;
        @(negedge clk); start_conv_pulse = 1'b0; load_req = 1'b0;
        m_run = '0;
        checks++; if (busy !== 1'b1 || shadow_full !== 1'b0) begin errors++; $display("FAIL restart_state got busy %b full %b expected 1 0", busy, shadow_full); end
        drive_rows(0, NUM_ROWS, 2, 0, 0, 24'h0, rd, dn, bad, gap, to);
        checks++; if (to || rd !== NUM_ROWS || dn !== 1) begin errors++; $display("FAIL restart_load got reads %0d dones %0d expected %0d 1", rd, dn, NUM_ROWS); end
        do_swap(1'b0);
        exp = ramp_bus();
        checks++; if (wgt_bus !== exp) begin errors++; $display("FAIL restart_bus byte %0d got %02h expected %02h", first_bad(wgt_bus, exp), wgt_bus[first_bad(wgt_bus, exp)*8 +: 8], exp[first_bad(wgt_bus, exp)*8 +: 8]); end
    endtask

    task automatic test_back_to_back();
        int rd, dn, bad, gap;
        bit to;
        logic [BANK_WIDTH-1:0] exp;
        start_load();
        drive_rows(0, NUM_ROWS, 0, 0, 2, 24'h0, rd, dn, bad, gap, to);
        do_swap(1'b1);
        exp = expected_bus();
        checks++; if (wgt_bus !== exp) begin errors++; $display("FAIL b2b_bus byte %0d got %02h expected %02h", first_bad(wgt_bus, exp), wgt_bus[first_bad(wgt_bus, exp)*8 +: 8], exp[first_bad(wgt_bus, exp)*8 +: 8]); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b expected 1", busy); end
        drive_rows(0, 10, 0, 0, 0, 24'h0, rd, dn, bad, gap, to);
        checks++; if (to || rd !== 10) begin errors++; $display("FAIL b2b_resume_reads got %0d expected 10", rd); end
        do_swap(1'b0);
        checks++; if (wgt_bus !== exp) begin errors++; $display("FAIL b2b_early_swap byte %0d changed", first_bad(wgt_bus, exp)); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_early_swap_busy got %b expected 1", busy); end
        drive_rows(10, NUM_ROWS - 10, 2, 2, 0, 24'h0, rd, dn, bad, gap, to);
        checks++; if (to || rd !== NUM_ROWS - 10 || dn !== 1) begin errors++; $display("FAIL b2b_second_load got reads %0d dones %0d expected %0d 1", rd, dn, NUM_ROWS - 10); end
        do_swap(1'b0);
        exp = ramp_bus();
        checks++; if (wgt_bus !== exp) begin errors++; $display("FAIL b2b_final_bus byte %0d got %02h expected %02h", first_bad(wgt_bus, exp), wgt_bus[first_bad(wgt_bus, exp)*8 +: 8], exp[first_bad(wgt_bus, exp)*8 +: 8]); end
    endtask

`ifdef WGT_LOADER_CKSUM_EN
    task automatic test_cksum();
        int rd, dn, bad, gap;
        bit to;
        start_load();
        drive_rows(0, NUM_ROWS, 0, 0, 1, 24'hFFFFFF, rd, dn, bad, gap, to);
        do_swap(1'b0);
        checks++; if (wgt_cksum !== 16'h8F70) begin errors++; $display("FAIL cksum_ff got %04h expected 8f70", wgt_cksum); end
        start_load();
        drive_rows(0, 20, 0, 0, 2, 24'h0, rd, dn, bad, gap, to);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (wgt_cksum !== 16'h0) begin errors++; $display("FAIL cksum_reset got %04h expected 0000", wgt_cksum); end
        checks++; if (wgt_bus !== '0 || busy !== 1'b0) begin errors++; $display("FAIL midload_reset got busy %b expected 0 with zero bus", busy); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_swap();
        test_stall();
        test_random_load();
        test_abort();
        test_restart();
        test_back_to_back();
`ifdef WGT_LOADER_CKSUM_EN
        test_cksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
